// File: rtl/serial_unpack_pkg.sv
// Shared constants for the serial unpacker: default geometry, derived
// counter/index widths and the two-state receive FSM encoding.
package serial_unpack_pkg;

  localparam int unsigned ENTRIES_DEF = 16;
  localparam int unsigned WIDTH_DEF   = 8;

  localparam int unsigned CNT_W = 7;  // bit position within a 128-bit frame
  localparam int unsigned IDX_W = 4;  // entry index within a frame
  localparam int unsigned BIT_W = 3;  // bit position within an entry

  localparam logic IDLE = 1'b0;
  localparam logic RECV = 1'b1;

endpackage

// File: rtl/unpack_bank.sv
// Shadow/committed register bank pair for the serial unpacker.
// Serial bits land in the shadow bank; a commit copies the whole shadow
// bank into the committed bank, which alone drives the readback port.
// Optional macro SERIAL_UNPACK_CMP_EN adds a frame-to-frame compare.
module unpack_bank
  import serial_unpack_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [BIT_W-1:0] wr_pos,
  input  logic             wr_bit,
  input  logic             commit,
  output logic [WIDTH-2:0] row_low,
`ifdef SERIAL_UNPACK_CMP_EN
  input  logic             cmp_req,
  output logic             mismatch,
`endif
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] shadow    [ENTRIES];
  logic [WIDTH-1:0] committed [ENTRIES];

  // Bit-granular shadow writes and whole-bank commit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        shadow[i]    <= '0;
        committed[i] <= '0;
      end
    end else begin
      if (wr_en) shadow[wr_idx][wr_pos] <= wr_bit;
      if (commit) begin
        for (int unsigned i = 0; i < ENTRIES; i++) committed[i] <= shadow[i];
      end
    end
  end

  assign row_low = shadow[wr_idx][WIDTH-2:0];
  assign rd_data = committed[rd_idx];

`ifdef SERIAL_UNPACK_CMP_EN
  logic             first_ok;
  logic             diff;
  logic [WIDTH-1:0] cmp_row;

  // The compare is evaluated on the edge that samples the final bit, so that
  // bit is merged in from wr_bit rather than read from the shadow bank.
  always_comb begin
    diff    = 1'b0;
    cmp_row = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      cmp_row = shadow[i];
      if (i == ENTRIES - 1) cmp_row[WIDTH-1] = wr_bit;
      if (cmp_row != committed[i]) diff = 1'b1;
    end
  end

  // Mismatch strobe lines up with frame_done; the first frame has no reference
  always_ff @(posedge clk) begin
    if (rst) begin
      first_ok <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= cmp_req & first_ok & diff;
      if (commit) first_ok <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/serial_unpack.sv
// Serial unpacker: rebuilds 16 {addr,data} bytes from a continuous LSB-first
// bit stream, strobes each byte, and commits full frames to a readable bank.
// Optional macro SERIAL_UNPACK_CMP_EN adds the 'mismatch' output.
module serial_unpack
  import serial_unpack_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena_in,
  input  logic               data_in,
  output logic               byte_valid,
  output logic [IDX_W-1:0]   byte_idx,
  output logic [WIDTH/2-1:0] addr_out,
  output logic [WIDTH/2-1:0] data_out,
  output logic               frame_done,
  output logic [7:0]         frame_cnt,
  output logic               abort,
`ifdef SERIAL_UNPACK_CMP_EN
  output logic               mismatch,
`endif
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [WIDTH-1:0]   rd_data
);

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-2:0] row_low;
  logic             byte_end;
  logic             frame_end;

  // In IDLE the counter is always zero, so sampling is simply gated by ena_in
  assign byte_end  = ena_in && (cnt[BIT_W-1:0] == '1);
  assign frame_end = ena_in && (cnt == '1);

  // Receive FSM, bit counter and output strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      byte_valid <= 1'b0;
      byte_idx   <= '0;
      addr_out   <= '0;
      data_out   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      abort      <= 1'b0;
    end else begin
      byte_valid <= byte_end;
      frame_done <= frame_end;
      abort      <= 1'b0;
      if (byte_end) begin
        byte_idx              <= cnt[CNT_W-1:BIT_W];
        {addr_out, data_out}  <= {data_in, row_low};
      end
      if (frame_end) frame_cnt <= frame_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (ena_in) begin
            state <= RECV;
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          if (ena_in) begin
            cnt <= cnt + 1'b1;
          end else begin
            abort <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  unpack_bank #(
    .ENTRIES (ENTRIES),
    .WIDTH   (WIDTH)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (ena_in),
    .wr_idx   (cnt[CNT_W-1:BIT_W]),
    .wr_pos   (cnt[BIT_W-1:0]),
    .wr_bit   (data_in),
    .commit   (frame_done),
    .row_low  (row_low),
`ifdef SERIAL_UNPACK_CMP_EN
    .cmp_req  (frame_end),
    .mismatch (mismatch),
`endif
    .rd_idx   (rd_idx),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_serial_unpack.sv
// Directed testbench for serial_unpack. Inputs change on the falling edge,
// a monitor samples outputs 1 ns after each rising edge.
// Define SERIAL_UNPACK_CMP_EN to also exercise the mismatch output.
module tb_serial_unpack;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena_in;
  logic       data_in;
  logic       byte_valid;
  logic [3:0] byte_idx;
  logic [3:0] addr_out;
  logic [3:0] data_out;
  logic       frame_done;
  logic [7:0] frame_cnt;
  logic       abort;
  logic [3:0] rd_idx;
  logic [7:0] rd_data;
`ifdef SERIAL_UNPACK_CMP_EN
  logic       mismatch;
`endif

  always #5 clk = ~clk;

  serial_unpack dut (
    .clk        (clk),
    .rst        (rst),
    .ena_in     (ena_in),
    .data_in    (data_in),
    .byte_valid (byte_valid),
    .byte_idx   (byte_idx),
    .addr_out   (addr_out),
    .data_out   (data_out),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .abort      (abort),
`ifdef SERIAL_UNPACK_CMP_EN
    .mismatch   (mismatch),
`endif
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor statistics
  int         cyc = 0;
  int         bv_cnt, fd_cnt, ab_cnt, idx_err, fd_gap, last_fd;
  int         mm_cnt, mm_fd, mm_unaligned;
  logic [7:0] fc_last, fc_prev, rd_at_fd, rd_after_fd;
  logic       rd_follow;
  logic [3:0] exp_idx;
  logic [7:0] bytes_seen [16];
  logic [7:0] cur_frame  [16];

  task automatic clear_stats();
    bv_cnt = 0; fd_cnt = 0; ab_cnt = 0; idx_err = 0; fd_gap = 0; last_fd = 0;
    mm_cnt = 0; mm_fd = 0; mm_unaligned = 0;
    fc_last = '0; fc_prev = '0; rd_at_fd = '1; rd_after_fd = '1;
    rd_follow = 1'b0; exp_idx = '0;
    for (int i = 0; i < 16; i++) bytes_seen[i] = '1;
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rd_follow) begin
      rd_after_fd = rd_data;
      rd_follow   = 1'b0;
    end
    if (byte_valid) begin
      if (byte_idx != exp_idx) idx_err++;
      exp_idx = byte_idx + 4'd1;
      bv_cnt++;
      bytes_seen[byte_idx] = {addr_out, data_out};
    end
    if (frame_done) begin
      fd_cnt++;
      fd_gap  = cyc - last_fd;
      last_fd = cyc;
      fc_prev = fc_last;
      fc_last = frame_cnt;
      if (fd_cnt == 1) begin
        rd_at_fd  = rd_data;
        rd_follow = 1'b1;
      end
    end
    if (abort) ab_cnt++;
`ifdef SERIAL_UNPACK_CMP_EN
    if (mismatch) begin
      mm_cnt++;
      mm_fd = fd_cnt;
      if (!frame_done) mm_unaligned++;
    end
`endif
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ena_in = 1'b0; data_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic send_bits(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ena_in  = 1'b1;
      data_in = cur_frame[i / 8][i % 8];
    end
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    ena_in = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input logic [3:0] idx, input logic [7:0] exp);
    rd_idx = idx;
    #1;
    check_val(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ena_in = 1'b0; data_in = 1'b0; rd_idx = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    check_val("rst_byte_valid", {31'd0, byte_valid}, 0);
    check_val("rst_frame_done", {31'd0, frame_done}, 0);
    check_val("rst_abort",      {31'd0, abort}, 0);
    check_val("rst_frame_cnt",  {24'd0, frame_cnt}, 0);
    check_val("rst_byte",       {20'd0, byte_idx, addr_out, data_out}, 0);
    read_chk("rst_rd0", 4'd0, 8'h00);

    // Steady frame 0xA0..0xAF
    do_reset();
    for (int i = 0; i < 16; i++) cur_frame[i] = 8'hA0 + 8'(i);
    rd_idx = 4'd3;
    send_bits(128);
    go_idle(4);
    check_val("t1_bv_cnt",    bv_cnt, 16);
    check_val("t1_idx_order", idx_err, 0);
    check_val("t1_entry5",    {24'd0, bytes_seen[5]}, 32'hA5);
    check_val("t1_entry15",   {24'd0, bytes_seen[15]}, 32'hAF);
    check_val("t1_fd_cnt",    fd_cnt, 1);
    check_val("t1_frame_cnt", {24'd0, frame_cnt}, 1);
    check_val("t1_rd_at_commit",    {24'd0, rd_at_fd}, 32'h00);
    check_val("t1_rd_after_commit", {24'd0, rd_after_fd}, 32'hA3);
    read_chk("t1_rd3", 4'd3, 8'hA3);
    check_val("t1_trailing_abort", ab_cnt, 1);

    // Same frame twice, back-to-back
    do_reset();
    send_bits(128);
    send_bits(128);
    go_idle(4);
    check_val("t2_fd_cnt",    fd_cnt, 2);
    check_val("t2_fd_gap",    fd_gap, 128);
    check_val("t2_frame_cnt", {24'd0, frame_cnt}, 2);
    check_val("t2_bv_cnt",    bv_cnt, 32);
    check_val("t2_idx_order", idx_err, 0);
`ifdef SERIAL_UNPACK_CMP_EN
    check_val("t2_mismatch", mm_cnt, 0);
`endif

    // Abort after 70 bits, then a clean frame
    do_reset();
    send_bits(70);
    go_idle(4);
    check_val("t3_abort",     ab_cnt, 1);
    check_val("t3_fd_cnt",    fd_cnt, 0);
    check_val("t3_bv_cnt",    bv_cnt, 8);
    check_val("t3_frame_cnt", {24'd0, frame_cnt}, 0);
    for (int r = 0; r < 16; r++) read_chk($sformatf("t3_rd%0d", r), 4'(r), 8'h00);
    clear_stats();
    for (int i = 0; i < 16; i++) cur_frame[i] = 8'h50 + 8'(i);
    send_bits(128);
    go_idle(4);
    check_val("t3_fd_after",  fd_cnt, 1);
    check_val("t3_fc_after",  {24'd0, frame_cnt}, 1);
    check_val("t3_idx_order", idx_err, 0);
    read_chk("t3_rd7", 4'd7, 8'h57);

    // Reset at bit 40 of the second frame
    do_reset();
    for (int i = 0; i < 16; i++) cur_frame[i] = 8'hA0 + 8'(i);
    send_bits(128);
    send_bits(40);
    check_val("t4_fc_before", {24'd0, frame_cnt}, 1);
    @(negedge clk);
    rst = 1'b1; ena_in = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t4_frame_cnt",  {24'd0, frame_cnt}, 0);
    check_val("t4_byte_valid", {31'd0, byte_valid}, 0);
    check_val("t4_byte",       {20'd0, byte_idx, addr_out, data_out}, 0);
    check_val("t4_frame_done", {31'd0, frame_done}, 0);
    read_chk("t4_rd3", 4'd3, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("t4_no_abort", ab_cnt, 0);
    check_val("t4_fc_after", {24'd0, frame_cnt}, 0);

    // 0x11 frames twice, then one with entry 9 = 0x99
    do_reset();
    for (int i = 0; i < 16; i++) cur_frame[i] = 8'h11;
    send_bits(128);
    send_bits(128);
    cur_frame[9] = 8'h99;
    send_bits(128);
    go_idle(4);
    check_val("t5_fd_cnt", fd_cnt, 3);
    read_chk("t5_rd9", 4'd9, 8'h99);
    read_chk("t5_rd8", 4'd8, 8'h11);
`ifdef SERIAL_UNPACK_CMP_EN
    check_val("t5_mm_cnt",       mm_cnt, 1);
    check_val("t5_mm_on_fd",     mm_fd, 3);
    check_val("t5_mm_unaligned", mm_unaligned, 0);
`endif

    // 256 frames: frame_cnt wraps on the last commit
    do_reset();
    for (int i = 0; i < 16; i++) cur_frame[i] = 8'(i * 17);
    for (int f = 0; f < 256; f++) send_bits(128);
    go_idle(4);
    check_val("t6_fd_cnt",    fd_cnt, 256);
    check_val("t6_fc_255",    {24'd0, fc_prev}, 255);
    check_val("t6_frame_cnt", {24'd0, frame_cnt}, 0);
    check_val("t6_fd_gap",    fd_gap, 128);
    read_chk("t6_rd15", 4'd15, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
